bucket_sched: RTL

//  Bucket-accumulation scheduler for the MSM engine: it decides, per point and per adder result, whether to park the operand in its bucket or to pair it with the bucket and send the pair to the pipelined point adder.
//  It sits between point_mem / result_buffer and the bucket RAM (2 ports) + adder; it drives control only, and the data path is external.

---
 rtl/bucket_sched.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/bucket_sched.sv
// Bucket-accumulation scheduler: parks points/results in buckets or pairs them for the point adder.
// Optional macro BUCKET_SCHED_STAT_EN adds saturating stall_cnt/pair_cnt outputs.
`timescale 1ns/1ps
module bucket_sched #(
  parameter int WIDTH_ID = 4,
  parameter int RD_LAT   = 1,
  parameter int INFL_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pm_valid,
  input  logic [WIDTH_ID-1:0] pm_id,
  output logic                pm_ready,
  input  logic                rb_valid,
  input  logic [WIDTH_ID-1:0] rb_id,
  output logic                r_en_a,
  output logic [WIDTH_ID-1:0] r_addr_a,
  output logic                w_en_a,
  output logic [WIDTH_ID-1:0] w_addr_a,
  output logic                r_en_b,
  output logic [WIDTH_ID-1:0] r_addr_b,
  output logic                w_en_b,
  output logic [WIDTH_ID-1:0] w_addr_b,
  output logic                add_vld,
  output logic                add_sel_a,
  output logic                add_sel_b,
  output logic [WIDTH_ID-1:0] add_id,
  input  logic                drain_req,
  output logic                drain_vld,
  output logic                drain_empty,
  output logic [WIDTH_ID-1:0] drain_id,
  output logic                drain_done,
  output logic                err,
  output logic [1:0]          fsm_state
`ifdef BUCKET_SCHED_STAT_EN
  ,
  output logic [31:0]         stall_cnt,
  output logic [31:0]         pair_cnt
`endif
);

  // Handshake: a point transfers on a cycle where pm_valid & pm_ready are both high;
  // pm_ready is combinational. rb_valid is never back-pressured.

  localparam int NB = 1 << WIDTH_ID;
  localparam logic [WIDTH_ID-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {S_RUN = 2'd0, S_WAIT = 2'd1, S_DRAIN = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [NB-1:0]       flag_q, flag_d;
  logic [WIDTH_ID-1:0] idx_q;
  logic [INFL_W-1:0]   inflight_q, inflight_d;
  logic                err_q;

  logic                stall_pm, pm_acc, rb_act, same_id, pend;
  logic                ra_en, wa_en, rb_en, wb_en;
  logic [WIDTH_ID-1:0] ra_addr, wa_addr, rb_addr, wb_addr;
  logic                iss, iss_sa, iss_sb;
  logic [WIDTH_ID-1:0] iss_id;
  logic                dr_v, dr_empty, dr_last;
  logic [WIDTH_ID-1:0] dr_id;
  logic                ovf, udf;

  // Add and drain pipes align issue with the RAM read data (1 + RD_LAT cycles).
  logic [RD_LAT:0]     av_q, asa_q, asb_q, dv_q, de_q, dl_q;
  logic [WIDTH_ID-1:0] aid_q [RD_LAT+1];
  logic [WIDTH_ID-1:0] did_q [RD_LAT+1];

  assign stall_pm = rb_valid & (rb_id != pm_id) & flag_q[rb_id] & flag_q[pm_id];
  assign pm_acc   = pm_valid & pm_ready;
  assign rb_act   = rb_valid & (state_q != S_DRAIN);
  assign same_id  = pm_acc & rb_act & (pm_id == rb_id);
  assign pend     = |av_q;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (drain_req) state_d = S_WAIT;
      S_WAIT:  if ((inflight_q == '0) && !rb_valid && !pend) state_d = S_DRAIN;
      S_DRAIN: if (idx_q == LAST_IDX) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pm_ready  = (state_q == S_RUN) & ~stall_pm;
    fsm_state = state_q;
  end

  // Per-cycle bucket decisions from the live flag register.
  always_comb begin
    flag_d   = flag_q;
    ra_en    = 1'b0; ra_addr = '0;
    wa_en    = 1'b0; wa_addr = '0;
    rb_en    = 1'b0; rb_addr = '0;
    wb_en    = 1'b0; wb_addr = '0;
    iss      = 1'b0; iss_sa  = 1'b0; iss_sb = 1'b0; iss_id = '0;
    dr_v     = 1'b0; dr_empty = 1'b0; dr_last = 1'b0; dr_id = '0;
    if (same_id) begin
      iss    = 1'b1;
      iss_id = pm_id;
    end else begin
      if (pm_acc) begin
        if (flag_q[pm_id]) begin
          ra_en = 1'b1; ra_addr = pm_id;
          iss = 1'b1; iss_sa = 1'b1; iss_id = pm_id;
          flag_d[pm_id] = 1'b0;
        end else begin
          wa_en = 1'b1; wa_addr = pm_id;
          flag_d[pm_id] = 1'b1;
        end
      end
      if (rb_act) begin
        if (flag_q[rb_id]) begin
          rb_en = 1'b1; rb_addr = rb_id;
          iss = 1'b1; iss_sb = 1'b1; iss_id = rb_id;
          flag_d[rb_id] = 1'b0;
        end else begin
          wb_en = 1'b1; wb_addr = rb_id;
          flag_d[rb_id] = 1'b1;
        end
      end
    end
    if (state_q == S_DRAIN) begin
      ra_en         = flag_q[idx_q];
      ra_addr       = flag_q[idx_q] ? idx_q : '0;
      flag_d[idx_q] = 1'b0;
      dr_v          = 1'b1;
      dr_empty      = ~flag_q[idx_q];
      dr_last       = (idx_q == LAST_IDX);
      dr_id         = idx_q;
    end
  end

  // In-flight count moves on issued adds and returning results.
  always_comb begin
    inflight_d = inflight_q;
    ovf        = 1'b0;
    udf        = 1'b0;
    case ({add_vld, rb_act})
      2'b10: if (inflight_q == '1) ovf = 1'b1; else inflight_d = inflight_q + 1'b1;
      2'b01: if (inflight_q == '0) udf = 1'b1; else inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q     <= '0;
      idx_q      <= '0;
      inflight_q <= '0;
      err_q      <= 1'b0;
      r_en_a <= 1'b0; r_addr_a <= '0; w_en_a <= 1'b0; w_addr_a <= '0;
      r_en_b <= 1'b0; r_addr_b <= '0; w_en_b <= 1'b0; w_addr_b <= '0;
      av_q <= '0; asa_q <= '0; asb_q <= '0;
      dv_q <= '0; de_q  <= '0; dl_q  <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        aid_q[i] <= '0;
        did_q[i] <= '0;
      end
    end else begin
      flag_q     <= flag_d;
      idx_q      <= (state_q == S_DRAIN) ? idx_q + 1'b1 : '0;
      inflight_q <= inflight_d;
      err_q      <= err_q | ovf | udf | (rb_valid & (state_q == S_DRAIN))
                    | (drain_req & (state_q != S_RUN));
      r_en_a <= ra_en; r_addr_a <= ra_addr; w_en_a <= wa_en; w_addr_a <= wa_addr;
      r_en_b <= rb_en; r_addr_b <= rb_addr; w_en_b <= wb_en; w_addr_b <= wb_addr;
      av_q[0] <= iss; asa_q[0] <= iss_sa; asb_q[0] <= iss_sb; aid_q[0] <= iss_id;
      dv_q[0] <= dr_v; de_q[0] <= dr_empty; dl_q[0] <= dr_last; did_q[0] <= dr_id;
      for (int i = 1; i <= RD_LAT; i++) begin
        av_q[i] <= av_q[i-1]; asa_q[i] <= asa_q[i-1]; asb_q[i] <= asb_q[i-1];
        aid_q[i] <= aid_q[i-1];
        dv_q[i] <= dv_q[i-1]; de_q[i] <= de_q[i-1]; dl_q[i] <= dl_q[i-1];
        did_q[i] <= did_q[i-1];
      end
    end
  end

  assign add_vld     = av_q[RD_LAT];
  assign add_sel_a   = asa_q[RD_LAT];
  assign add_sel_b   = asb_q[RD_LAT];
  assign add_id      = aid_q[RD_LAT];
  assign drain_vld   = dv_q[RD_LAT];
  assign drain_empty = de_q[RD_LAT];
  assign drain_id    = did_q[RD_LAT];
  assign drain_done  = dv_q[RD_LAT] & dl_q[RD_LAT];
  assign err         = err_q;

`ifdef BUCKET_SCHED_STAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      pair_cnt  <= '0;
    end else begin
      if (pm_valid && !pm_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (add_vld && (pair_cnt != '1))                pair_cnt  <= pair_cnt + 32'd1;
    end
  end
`endif

endmodule
